// File: rtl/exp7_unidade_controle.sv
// Moore control unit for the Experiment 7 memory game: sequences LED display,
// player input checking, new-play recording and end-of-game reporting.
module exp7_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimL,
    input  logic       timeout,
    input  logic       leds_meio,
    input  logic       leds_fim,
    output logic       zeraCR,
    output logic       zeraE,
    output logic       contaCR,
    output logic       contaE,
    output logic       limpaRC,
    output logic       registraRC,
    output logic       zeraLeds,
    output logic       registraLeds,
    output logic       contaT,
    output logic       contaL,
    output logic       led_selector,
    output logic       led_turn_off,
    output logic       ram_enable,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [4:0] db_estado
);

    typedef enum logic [4:0] {
        inicial        = 5'h00,
        preparacao     = 5'h01,
        mostra_led     = 5'h02,
        apaga_led      = 5'h03,
        proximo_mostra = 5'h04,
        fim_mostra     = 5'h05,
        espera_jogada  = 5'h06,
        registra       = 5'h07,
        comparacao     = 5'h08,
        proxima_jogada = 5'h09,
        avanca_escrita = 5'h0A,
        espera_nova    = 5'h0B,
        registra_nova  = 5'h0C,
        escreve        = 5'h0D,
        proxima_rodada = 5'h0E,
        fim_acertou    = 5'h0F,
        fim_errou      = 5'h10,
        fim_timeout    = 5'h11
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= inicial;
        else        state <= next_state;
    end

    always_comb begin
        next_state   = inicial;
        zeraCR       = 1'b0;
        zeraE        = 1'b0;
        contaCR      = 1'b0;
        contaE       = 1'b0;
        limpaRC      = 1'b0;
        registraRC   = 1'b0;
        zeraLeds     = 1'b0;
        registraLeds = 1'b0;
        contaT       = 1'b0;
        contaL       = 1'b0;
        led_selector = 1'b0;
        led_turn_off = 1'b0;
        ram_enable   = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        db_timeout   = 1'b0;

        unique case (state)
            inicial: next_state = iniciar ? preparacao : inicial;
            preparacao: begin
                zeraE      = 1'b1;
                zeraCR     = 1'b1;
                limpaRC    = 1'b1;
                zeraLeds   = 1'b1;
                next_state = mostra_led;
            end
            mostra_led: begin
                registraLeds = 1'b1;
                led_selector = 1'b1;
                contaL       = 1'b1;
                next_state   = leds_meio ? apaga_led : mostra_led;
            end
            apaga_led: begin
                registraLeds = 1'b1;
                led_turn_off = 1'b1;
                contaL       = 1'b1;
                if (leds_fim) next_state = enderecoIgualRodada ? fim_mostra : proximo_mostra;
                else          next_state = apaga_led;
            end
            proximo_mostra: begin
                contaE     = 1'b1;
                next_state = mostra_led;
            end
            fim_mostra: begin
                zeraE        = 1'b1;
                led_turn_off = 1'b1;
                next_state   = espera_jogada;
            end
            espera_jogada: begin
                contaT       = 1'b1;
                registraLeds = 1'b1;
                // a press in the same cycle as timeout still counts
                if (jogada_feita) next_state = registra;
                else if (timeout) next_state = fim_timeout;
                else              next_state = espera_jogada;
            end
            registra: begin
                registraRC = 1'b1;
                next_state = comparacao;
            end
            comparacao: begin
                if (!jogada_correta)          next_state = fim_errou;
                else if (!enderecoIgualRodada) next_state = proxima_jogada;
                else if (fimL)                next_state = fim_acertou;
                else                          next_state = avanca_escrita;
            end
            proxima_jogada: begin
                contaE     = 1'b1;
                next_state = espera_jogada;
            end
            avanca_escrita: begin
                contaE     = 1'b1;
                next_state = espera_nova;
            end
            espera_nova: begin
                contaT       = 1'b1;
                registraLeds = 1'b1;
                if (jogada_feita) next_state = registra_nova;
                else if (timeout) next_state = fim_timeout;
                else              next_state = espera_nova;
            end
            registra_nova: begin
                registraRC = 1'b1;
                next_state = escreve;
            end
            escreve: begin
                ram_enable = 1'b1;
                next_state = proxima_rodada;
            end
            proxima_rodada: begin
                contaCR    = 1'b1;
                zeraE      = 1'b1;
                limpaRC    = 1'b1;
                next_state = mostra_led;
            end
            fim_acertou: begin
                pronto     = 1'b1;
                ganhou     = 1'b1;
                next_state = iniciar ? preparacao : fim_acertou;
            end
            fim_errou: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                next_state = iniciar ? preparacao : fim_errou;
            end
            fim_timeout: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
                next_state = iniciar ? preparacao : fim_timeout;
            end
            default: next_state = inicial;
        endcase
    end

    assign db_estado = state;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Directed bench for exp7_unidade_controle: expected state/outputs are queued
// when each step is driven and compared after the following clock edge.
module tb_exp7_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, jogada_feita, jogada_correta, enderecoIgualRodada;
    logic       fimL, timeout, leds_meio, leds_fim;
    logic       zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds;
    logic       registraLeds, contaT, contaL, led_selector, led_turn_off, ram_enable;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [4:0] db_estado;

    int total = 0;
    int bad   = 0;
    logic [4:0] sb[$];

    // flag vector bits: {iniciar, jf, jc, eir, fimL, timeout, leds_meio, leds_fim}
    localparam logic [7:0] INI = 8'h80, JF = 8'h40, JC = 8'h20, EIR = 8'h10;
    localparam logic [7:0] FL  = 8'h08, TO = 8'h04, LM = 8'h02, LF = 8'h01;

    // output vector bits, MSB first
    localparam logic [16:0] O_ZCR = 17'h10000, O_ZE = 17'h08000, O_CCR = 17'h04000;
    localparam logic [16:0] O_CE  = 17'h02000, O_LRC = 17'h01000, O_RRC = 17'h00800;
    localparam logic [16:0] O_ZL  = 17'h00400, O_RL = 17'h00200, O_CT = 17'h00100;
    localparam logic [16:0] O_CL  = 17'h00080, O_SEL = 17'h00040, O_OFF = 17'h00020;
    localparam logic [16:0] O_RAM = 17'h00010, O_PR = 17'h00008, O_GA = 17'h00004;
    localparam logic [16:0] O_PE  = 17'h00002, O_DT = 17'h00001;

    exp7_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
        .enderecoIgualRodada(enderecoIgualRodada), .fimL(fimL), .timeout(timeout),
        .leds_meio(leds_meio), .leds_fim(leds_fim),
        .zeraCR(zeraCR), .zeraE(zeraE), .contaCR(contaCR), .contaE(contaE),
        .limpaRC(limpaRC), .registraRC(registraRC), .zeraLeds(zeraLeds),
        .registraLeds(registraLeds), .contaT(contaT), .contaL(contaL),
        .led_selector(led_selector), .led_turn_off(led_turn_off),
        .ram_enable(ram_enable), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] expected_outputs(input logic [4:0] st);
        case (st)
            5'h01:   return O_ZE | O_ZCR | O_LRC | O_ZL;
            5'h02:   return O_RL | O_SEL | O_CL;
            5'h03:   return O_RL | O_OFF | O_CL;
            5'h04:   return O_CE;
            5'h05:   return O_ZE | O_OFF;
            5'h06:   return O_CT | O_RL;
            5'h07:   return O_RRC;
            5'h09:   return O_CE;
            5'h0A:   return O_CE;
            5'h0B:   return O_CT | O_RL;
            5'h0C:   return O_RRC;
            5'h0D:   return O_RAM;
            5'h0E:   return O_CCR | O_ZE | O_LRC;
            5'h0F:   return O_PR | O_GA;
            5'h10:   return O_PR | O_PE;
            5'h11:   return O_PR | O_PE | O_DT;
            default: return '0;
        endcase
    endfunction

    task automatic compare_head(input string tag);
        logic [4:0]  exp_st;
        logic [16:0] exp_out, act_out;
        exp_st  = sb.pop_front();
        exp_out = expected_outputs(exp_st);
        act_out = {zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds,
                   registraLeds, contaT, contaL, led_selector, led_turn_off,
                   ram_enable, pronto, ganhou, perdeu, db_timeout};
        total++;
        assert (db_estado === exp_st) else begin
            bad++;
            $error("FAIL %s state: got %h expected %h", tag, db_estado, exp_st);
        end
        total++;
        assert (act_out === exp_out) else begin
            bad++;
            $error("FAIL %s outputs (state %h): got %h expected %h", tag, exp_st, act_out, exp_out);
        end
    endtask

    task automatic set_flags(input logic [7:0] f);
        {iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
         fimL, timeout, leds_meio, leds_fim} = f;
    endtask

    // drive flags, expect exp_st after the next rising edge
    task automatic step(input logic [7:0] f, input logic [4:0] exp_st, input string tag);
        set_flags(f);
        sb.push_back(exp_st);
        @(posedge clock);
        #1;
        compare_head(tag);
    endtask

    task automatic check_now(input logic [4:0] exp_st, input string tag);
        sb.push_back(exp_st);
        compare_head(tag);
    endtask

    task automatic start_game();
        step(INI, 5'h01, "start_prep");
        step(8'h00, 5'h02, "start_show");
    endtask

    // from 02, show addresses 0..r, end in 06
    task automatic show_round(input int unsigned r);
        for (int unsigned a = 0; a <= r; a++) begin
            step(LM, 5'h03, "show_off");
            if (a < r) begin
                step(LF, 5'h04, "show_next");
                step(8'h00, 5'h02, "show_on");
            end else begin
                step(LF | EIR, 5'h05, "show_end");
            end
        end
        step(8'h00, 5'h06, "wait_play");
    endtask

    // from 06, play all of round r correctly; ends in 02 or 0F
    task automatic play_round(input int unsigned r);
        for (int unsigned a = 0; a <= r; a++) begin
            step(JF, 5'h07, "press");
            step(8'h00, 5'h08, "compare");
            if (a < r) begin
                step(JC, 5'h09, "next_play");
                step(8'h00, 5'h06, "wait_play");
            end else if (r < 15) begin
                step(JC | EIR, 5'h0A, "adv_write");
                step(8'h00, 5'h0B, "wait_new");
                step(JF, 5'h0C, "reg_new");
                step(8'h00, 5'h0D, "write");
                step(8'h00, 5'h0E, "next_round");
                step(8'h00, 5'h02, "round_show");
            end else begin
                step(JC | EIR | FL, 5'h0F, "win");
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        set_flags(8'h00);
        #12;
        check_now(5'h00, "reset_state");
        reset = 1'b1;
        step(8'h00, 5'h00, "idle_hold");

        // round 0 correct, then write a new play; round 1 correct; round 2 wrong at address 1
        start_game();
        step(JF, 5'h02, "ignore_press_in_show");
        show_round(0);
        play_round(0);
        show_round(1);
        play_round(1);
        show_round(2);
        step(JF, 5'h07, "r2_press0");
        step(8'h00, 5'h08, "r2_cmp0");
        step(JC, 5'h09, "r2_next");
        step(8'h00, 5'h06, "r2_wait1");
        step(JF, 5'h07, "r2_press1");
        step(8'h00, 5'h08, "r2_cmp1");
        step(EIR, 5'h10, "wrong_play");
        step(JF | JC, 5'h10, "lost_hold");
        step(8'h00, 5'h10, "lost_hold2");

        // timeout in 06, then simultaneous press+timeout, then timeout in 0B
        start_game();
        show_round(0);
        step(TO, 5'h11, "timeout_06");
        step(8'h00, 5'h11, "timeout_hold");
        start_game();
        show_round(0);
        step(JF | TO, 5'h07, "press_beats_timeout");
        step(8'h00, 5'h08, "cmp_after_tie");
        step(JC | EIR, 5'h0A, "adv_write_t");
        step(8'h00, 5'h0B, "wait_new_t");
        step(TO, 5'h11, "timeout_0B");

        // asynchronous reset during 03
        start_game();
        step(LM, 5'h03, "pre_reset_03");
        #2 reset = 1'b0;
        #1 check_now(5'h00, "async_reset_03");
        #3 reset = 1'b1;
        step(INI, 5'h01, "restart_after_reset");
        step(8'h00, 5'h02, "restart_show");

        // asynchronous reset during 0D drops ram_enable immediately
        show_round(0);
        step(JF, 5'h07, "pre_write_press");
        step(8'h00, 5'h08, "pre_write_cmp");
        step(JC | EIR, 5'h0A, "pre_write_adv");
        step(8'h00, 5'h0B, "pre_write_wait");
        step(JF, 5'h0C, "pre_write_reg");
        step(8'h00, 5'h0D, "pre_write_0D");
        #2 reset = 1'b0;
        #1 check_now(5'h00, "async_reset_0D");
        #3 reset = 1'b1;
        step(8'h00, 5'h00, "idle_after_reset");

        // full 16-round winning game
        start_game();
        for (int unsigned r = 0; r < 16; r++) begin
            show_round(r);
            play_round(r);
        end
        step(JF | TO, 5'h0F, "win_hold");
        step(INI, 5'h01, "restart_after_win");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
